// File: rtl/matrix_mac_engine.sv
// matrix_mac_engine: sequential N x N unsigned matrix multiplier (C = A x B)
// built around a single multiply-accumulate unit. Operands are loaded through
// a write port while idle; results drain row-major over a valid/ready stream.
// Optional build macro MATRIX_SAT_EN: the accumulator saturates at
// 2^ACC_W-1 on carry instead of wrapping. The overflow flag is set on any
// carry in both builds.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | operand writes accepted, waiting for start
// MAC   | one A[i][k]*B[k][j] accumulation per cycle, k = 0 .. N-1
// OUT   | C[i][j] presented on the stream until accepted
// FIN   | one-cycle done pulse, then back to IDLE
module matrix_mac_engine #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic              wr_sel_i,
  input  logic [IDX_W-1:0]  wr_row_i,
  input  logic [IDX_W-1:0]  wr_col_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [IDX_W-1:0]  out_row_o,
  output logic [IDX_W-1:0]  out_col_o,
  output logic [ACC_W-1:0]  out_data_o,
  output logic              done_o,
  output logic              overflow_o
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = ACC_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT, S_FIN} state_t;

  state_t             state_q;
  logic [DATA_W-1:0]  a_q [N][N];
  logic [DATA_W-1:0]  b_q [N][N];
  logic [IDX_W-1:0]   i_q, j_q, k_q;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [PROD_W-1:0]  prod;
  logic [SUM_W-1:0]   sum;
  logic               carry;
  logic               idx_ok;

  logic               busy_q, valid_q, done_q, ovf_q;
  logic [IDX_W-1:0]   row_q, col_q;
  logic [ACC_W-1:0]   data_q;

  // When N is a power of two every encodable index is in range.
  if (N == (1 << IDX_W)) begin : g_idx_full
    assign idx_ok = 1'b1;
  end else begin : g_idx_check
    assign idx_ok = (int'(wr_row_i) < N) && (int'(wr_col_i) < N);
  end

  // Operand storage: written only while idle so a run sees stable operands.
  always_ff @(posedge clk_i) begin
    if (state_q == S_IDLE && wr_en_i && idx_ok) begin
      if (wr_sel_i) b_q[wr_row_i][wr_col_i] <= wr_data_i;
      else          a_q[wr_row_i][wr_col_i] <= wr_data_i;
    end
  end

  // MAC datapath: one product per cycle, carry out of ACC_W flags overflow.
  always_comb begin
    prod  = PROD_W'(a_q[i_q][k_q]) * PROD_W'(b_q[k_q][j_q]);
    sum   = {1'b0, acc_q} + SUM_W'(prod);
    carry = sum[ACC_W];
`ifdef MATRIX_SAT_EN
    acc_d = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    acc_d = sum[ACC_W-1:0];
`endif
  end

  // Sequencer with registered stream/status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_MAC;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_MAC: begin
          acc_q <= acc_d;
          if (carry) ovf_q <= 1'b1;
          if (k_q == IDX_W'(N - 1)) begin
            state_q <= S_OUT;
            valid_q <= 1'b1;
            data_q  <= acc_d;
            row_q   <= i_q;
            col_q   <= j_q;
          end else begin
            k_q <= k_q + IDX_W'(1);
          end
        end
        S_OUT: begin
          if (out_ready_i) begin
            valid_q <= 1'b0;
            if (i_q == IDX_W'(N - 1) && j_q == IDX_W'(N - 1)) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_MAC;
              acc_q   <= '0;
              k_q     <= '0;
              if (j_q == IDX_W'(N - 1)) begin
                j_q <= '0;
                i_q <= i_q + IDX_W'(1);
              end else begin
                j_q <= j_q + IDX_W'(1);
              end
            end
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign out_valid_o = valid_q;
  assign out_row_o   = row_q;
  assign out_col_o   = col_q;
  assign out_data_o  = data_q;
  assign done_o      = done_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Testbench for matrix_mac_engine (N=4, DATA_W=8, ACC_W=16 so overflow is
// reachable). Expected results come from a plain-arithmetic matrix product.
module tb_matrix_mac_engine;
  localparam int N      = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int IDX_W  = 2;
  localparam longint MAXV = (64'd1 << ACC_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en, wr_sel, start, out_ready;
  logic [IDX_W-1:0]  wr_row, wr_col;
  logic [DATA_W-1:0] wr_data;
  logic              busy, out_valid, done, overflow;
  logic [IDX_W-1:0]  out_row, out_col;
  logic [ACC_W-1:0]  out_data;

  always #5 clk = ~clk;

  matrix_mac_engine #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .wr_en_i(wr_en), .wr_sel_i(wr_sel), .wr_row_i(wr_row), .wr_col_i(wr_col),
    .wr_data_i(wr_data), .start_i(start), .busy_o(busy),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_row_o(out_row), .out_col_o(out_col), .out_data_o(out_data),
    .done_o(done), .overflow_o(overflow)
  );

  int     total = 0;
  int     bad   = 0;
  int     ma [N][N];
  int     mb [N][N];
  longint exp_v [N][N];
  bit     exp_ovf;

  // Reference: full-precision dot products, then wrap or clamp to ACC_W.
  function automatic void model();
    exp_ovf = 1'b0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        longint t = 0;
        for (int k = 0; k < N; k++) t += longint'(ma[r][k]) * longint'(mb[k][c]);
        if (t > MAXV) begin
          exp_ovf = 1'b1;
`ifdef MATRIX_SAT_EN
          exp_v[r][c] = MAXV;
`else
          exp_v[r][c] = t % (MAXV + 1);
`endif
        end else begin
          exp_v[r][c] = t;
        end
      end
  endfunction

  task automatic write_elem(input bit sel, input int r, input int c, input int v);
    wr_en = 1'b1; wr_sel = sel; wr_row = IDX_W'(r); wr_col = IDX_W'(c);
    wr_data = DATA_W'(v);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic load_all();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        write_elem(1'b0, r, c, ma[r][c]);
        write_elem(1'b1, r, c, mb[r][c]);
      end
  endtask

  task automatic fill_random(input int lo, input int hi);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = int'($urandom_range(hi, lo));
        mb[r][c] = int'($urandom_range(hi, lo));
      end
  endtask

  // Start a run, drain and check the whole stream, then check FIN and idle.
  task automatic run_check(input string tag, input int stall, input bit noise,
                           input bit same_wr);
    int idx = 0;
    int cyc;
    int wait_cnt = 0;
    int dones = 0;
    bit first = 1'b1;
    bit acc;
    model();
    start = 1'b1;
    if (same_wr) begin
      wr_en = 1'b1; wr_sel = 1'b0; wr_row = '0; wr_col = '0;
      wr_data = DATA_W'(ma[0][0]);
    end
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0; cyc = 1;
    total++;
    if (busy !== 1'b1 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL %s start_status: busy=%b overflow=%b want busy=1 overflow=0", tag, busy, overflow);
    end
    while (idx < N * N && cyc < 2000) begin
      acc = 1'b0;
      if (done === 1'b1) dones++;
      if (out_valid === 1'b1) begin
        if (noise) begin start = 1'b0; wr_en = 1'b0; end
        if (first) begin
          first = 1'b0;
          total++;
          if (cyc != N + 1) begin
            bad++;
            $display("FAIL %s first_valid_latency: got cycle %0d want %0d", tag, cyc, N + 1);
          end
        end
        total++;
        if (out_row !== IDX_W'(idx / N) || out_col !== IDX_W'(idx % N) ||
            out_data !== ACC_W'(exp_v[idx / N][idx % N])) begin
          bad++;
          $display("FAIL %s element%0d: got (%0d,%0d)=%0d want (%0d,%0d)=%0d", tag, idx,
                   out_row, out_col, out_data, idx / N, idx % N, exp_v[idx / N][idx % N]);
        end
        if (wait_cnt < stall) begin
          out_ready = 1'b0;
          wait_cnt++;
        end else begin
          out_ready = 1'b1;
          acc = 1'b1;
        end
      end else begin
        out_ready = (stall > 0) ? 1'($urandom_range(1, 0)) : 1'b1;
        if (noise) begin
          start = 1'b1; wr_en = 1'b1; wr_sel = 1'($urandom);
          wr_row = IDX_W'($urandom); wr_col = IDX_W'($urandom);
          wr_data = DATA_W'($urandom);
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin idx++; wait_cnt = 0; end
    end
    start = 1'b0; wr_en = 1'b0; out_ready = 1'b0;
    total++;
    if (idx < N * N) begin
      bad++;
      $display("FAIL %s stream_timeout: got %0d elements want %0d", tag, idx, N * N);
      return;
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0 || dones != 0) begin
      bad++;
      $display("FAIL %s fin_cycle: done=%b busy=%b valid=%b early_dones=%0d want 1 1 0 0",
               tag, done, busy, out_valid, dones);
    end
    if (stall == 0) begin
      total++;
      if (cyc != 1 + N * N * (N + 1)) begin
        bad++;
        $display("FAIL %s run_length: got %0d want %0d", tag, cyc - 1, N * N * (N + 1));
      end
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || overflow !== exp_ovf) begin
      bad++;
      $display("FAIL %s after_fin: done=%b busy=%b overflow=%b want 0 0 %b",
               tag, done, busy, overflow, exp_ovf);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 ||
        out_row !== '0 || out_col !== '0 || out_data !== '0) begin
      bad++;
      $display("FAIL reset_values: busy=%b valid=%b done=%b ovf=%b row=%0d col=%0d data=%0d want all 0",
               busy, out_valid, done, overflow, out_row, out_col, out_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_identity();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = (r == c) ? 1 : 0;
        mb[r][c] = 4 * r + c;
      end
    load_all();
    run_check("identity", 0, 1'b0, 1'b0);
  endtask

  task automatic test_known_product();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = 0;
        mb[r][c] = 0;
      end
    ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
    mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
    load_all();
    run_check("known_product", 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_pressure();
    run_check("back_pressure", 5, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = 255;
        mb[r][c] = 255;
      end
    load_all();
    run_check("overflow", 0, 1'b0, 1'b0);
    run_check("overflow_rerun", 1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 3; n++) begin
      fill_random(0, 255);
      load_all();
      run_check("random", n, 1'b0, 1'b0);
    end
    fill_random(0, 60);
    load_all();
    run_check("random_small", 2, 1'b0, 1'b0);
  endtask

  task automatic test_ignored_inputs();
    fill_random(0, 120);
    load_all();
    run_check("ignored_inputs", 0, 1'b1, 1'b0);
    run_check("ignored_inputs_rerun", 0, 1'b0, 1'b0);
  endtask

  task automatic test_write_with_start();
    ma[0][0] = (ma[0][0] + 77) % 256;
    run_check("write_with_start", 0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    int cnt = 0;
    bit seen_bad = 1'b0;
    fill_random(128, 255);
    load_all();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; out_ready = 1'b1;
    while (out_valid !== 1'b1 && cnt < 100) begin @(posedge clk); #1; cnt++; end
    @(posedge clk); #1;
    out_ready = 1'b0;
    while (out_valid !== 1'b1 && cnt < 100) begin @(posedge clk); #1; cnt++; end
    total++;
    if (cnt >= 100) begin
      bad++;
      $display("FAIL reset_mid_run_reach: second element not seen within %0d cycles", cnt);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 ||
        out_row !== '0 || out_col !== '0 || out_data !== '0) begin
      bad++;
      $display("FAIL reset_mid_run_values: busy=%b valid=%b done=%b ovf=%b row=%0d col=%0d data=%0d want all 0",
               busy, out_valid, done, overflow, out_row, out_col, out_data);
    end
    out_ready = 1'b1;
    repeat (N + 3) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) seen_bad = 1'b1;
    end
    out_ready = 1'b0;
    total++;
    if (seen_bad) begin
      bad++;
      $display("FAIL reset_mid_run_quiet: got activity after reset want idle");
    end
    fill_random(0, 255);
    load_all();
    run_check("after_reset_run", 0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_col = '0;
    wr_data = '0; start = 1'b0; out_ready = 1'b0;
    test_reset();
    test_identity();
    test_known_product();
    test_back_pressure();
    test_overflow();
    test_random();
    test_ignored_inputs();
    test_write_with_start();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
